// File: rtl/button_event_arbiter_pkg.sv
// Shared types for the pushbutton event front end.
package button_event_arbiter_pkg;

   typedef enum logic [0:0] {
      ARB_IDLE  = 1'b0,
      ARB_OFFER = 1'b1
   } arb_state_t;

   localparam arb_state_t ARB_RESET_STATE = ARB_IDLE;

endpackage

// File: rtl/button_event_arbiter_btn_channel.sv
// One pushbutton channel: synchroniser, level debouncer, press-length timer
// and a single-entry pending event slot with sticky overflow flag.
module btn_channel #(
   parameter int DEB_CYCLES  = 1000000,
   parameter int LONG_CYCLES = 100000000,
   parameter int CNT_W       = 28
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   input  logic grant_clr,
   input  logic ovf_clr,
   output logic level,
   output logic pend,
   output logic ptype,
   output logic ovf
);

   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
   localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             sync1_q, sync2_q;
   logic             db_q, db_d;
   logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic             pend_q, pend_d;
   logic             type_q, type_d;
   logic             ovf_q, ovf_d;
   logic             fall;

   always_comb begin
      db_d       = db_q;
      deb_cnt_d  = '0;
      hold_cnt_d = hold_cnt_q;
      pend_d     = pend_q & ~grant_clr;
      type_d     = type_q;
      ovf_d      = ovf_q & ~ovf_clr;
      fall       = 1'b0;

      if (sync2_q != db_q) begin
         if (deb_cnt_q == DEB_LAST) begin
            db_d = ~db_q;
         end else begin
            deb_cnt_d = deb_cnt_q + CNT_ONE;
         end
      end

      if (db_d && !db_q) begin
         hold_cnt_d = '0;
      end else if (db_q && (hold_cnt_q != LONG_MAX)) begin
         hold_cnt_d = hold_cnt_q + CNT_ONE;
      end

      // A release landing on the grant cycle replaces the slot rather than overflowing it.
      fall = db_q && !db_d;
      if (fall) begin
         if (pend_q && !grant_clr) begin
            ovf_d = 1'b1;
         end else begin
            pend_d = 1'b1;
            type_d = (hold_cnt_q >= LONG_MAX);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         db_q       <= 1'b0;
         deb_cnt_q  <= '0;
         hold_cnt_q <= '0;
         pend_q     <= 1'b0;
         type_q     <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         sync1_q    <= raw;
         sync2_q    <= sync1_q;
         db_q       <= db_d;
         deb_cnt_q  <= deb_cnt_d;
         hold_cnt_q <= hold_cnt_d;
         pend_q     <= pend_d;
         type_q     <= type_d;
         ovf_q      <= ovf_d;
      end
   end

   assign level = db_q;
   assign pend  = pend_q;
   assign ptype = type_q;
   assign ovf   = ovf_q;

endmodule

// File: rtl/button_event_arbiter.sv
// Pushbutton front end: N debounced channels feeding one round-robin
// valid/ready event port.
//
//   state     | meaning
//   ARB_IDLE  | no offer; latch the next pending channel at/after ptr
//   ARB_OFFER | evt_valid high, id/long frozen until evt_ready
module button_event_arbiter
   import button_event_arbiter_pkg::*;
#(
   parameter int N_BTN       = 4,
   parameter int DEB_CYCLES  = 1000000,
   parameter int LONG_CYCLES = 100000000,
   parameter int CNT_W       = 28,
   parameter int ID_W        = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_in,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [ID_W-1:0]  evt_id,
   output logic             evt_long,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] ovf,
   input  logic             ovf_clr
);

   logic [N_BTN-1:0] pend;
   logic [N_BTN-1:0] pend_type;
   logic [N_BTN-1:0] grant_clr;

   arb_state_t       state_q, state_d;
   logic [ID_W-1:0]  ptr_q, ptr_d;
   logic [ID_W-1:0]  id_q, id_d;
   logic             long_q, long_d;

   logic             found_hi, found_lo;
   logic [ID_W-1:0]  pick_hi, pick_lo;
   logic             long_hi, long_lo;

   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      btn_channel #(
         .DEB_CYCLES  (DEB_CYCLES),
         .LONG_CYCLES (LONG_CYCLES),
         .CNT_W       (CNT_W)
      ) u_ch (
         .clk       (clk),
         .rst       (rst),
         .raw       (btn_in[i]),
         .grant_clr (grant_clr[i]),
         .ovf_clr   (ovf_clr),
         .level     (btn_level[i]),
         .pend      (pend[i]),
         .ptype     (pend_type[i]),
         .ovf       (ovf[i])
      );
   end

   // Round robin without modulo: first pending at/after ptr, else lowest pending.
   always_comb begin
      found_hi = 1'b0;
      found_lo = 1'b0;
      pick_hi  = '0;
      pick_lo  = '0;
      long_hi  = 1'b0;
      long_lo  = 1'b0;
      for (int i = 0; i < N_BTN; i++) begin
         if (!found_hi && pend[i] && (ID_W'(i) >= ptr_q)) begin
            found_hi = 1'b1;
            pick_hi  = ID_W'(i);
            long_hi  = pend_type[i];
         end
         if (!found_lo && pend[i]) begin
            found_lo = 1'b1;
            pick_lo  = ID_W'(i);
            long_lo  = pend_type[i];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      id_d      = id_q;
      long_d    = long_q;
      grant_clr = '0;
      case (state_q)
         ARB_IDLE: begin
            if (found_lo) begin
               state_d = ARB_OFFER;
               id_d    = found_hi ? pick_hi : pick_lo;
               long_d  = found_hi ? long_hi : long_lo;
            end
         end
         ARB_OFFER: begin
            if (evt_ready) begin
               state_d = ARB_IDLE;
               for (int i = 0; i < N_BTN; i++) begin
                  if (ID_W'(i) == id_q) grant_clr[i] = 1'b1;
               end
               ptr_d = (id_q == ID_W'(N_BTN - 1)) ? '0 : id_q + ID_W'(1);
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ARB_RESET_STATE;
         ptr_q   <= '0;
         id_q    <= '0;
         long_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         long_q  <= long_d;
      end
   end

   assign evt_valid = (state_q == ARB_OFFER);
   assign evt_id    = id_q;
   assign evt_long  = long_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter with short debounce/long thresholds.
module tb_button_event_arbiter;

   localparam int N_BTN = 4;
   localparam int DEB   = 4;
   localparam int LONG  = 20;
   localparam int CNT_W = 28;
   localparam int ID_W  = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic [N_BTN-1:0] btn_in;
   logic             evt_valid;
   logic             evt_ready;
   logic [ID_W-1:0]  evt_id;
   logic             evt_long;
   logic [N_BTN-1:0] btn_level;
   logic [N_BTN-1:0] ovf;
   logic             ovf_clr;

   int   total = 0;
   int   bad   = 0;
   int   ev_n  = 0;
   int   ev_id_a [64];
   logic ev_long_a [64];
   int   base;

   always #5 clk = ~clk;

   button_event_arbiter #(
      .N_BTN       (N_BTN),
      .DEB_CYCLES  (DEB),
      .LONG_CYCLES (LONG),
      .CNT_W       (CNT_W),
      .ID_W        (ID_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_in    (btn_in),
      .evt_valid (evt_valid),
      .evt_ready (evt_ready),
      .evt_id    (evt_id),
      .evt_long  (evt_long),
      .btn_level (btn_level),
      .ovf       (ovf),
      .ovf_clr   (ovf_clr)
   );

   // Log every accepted event in order.
   always @(posedge clk) begin
      if (!rst && evt_valid && evt_ready && ev_n < 64) begin
         ev_id_a[ev_n]   = int'(evt_id);
         ev_long_a[ev_n] = evt_long;
         ev_n++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input int ch, input int hi, input int lo);
      btn_in[ch] = 1'b1;
      tick(hi);
      btn_in[ch] = 1'b0;
      tick(lo);
   endtask

   task automatic hold_check(input int n);
      for (int i = 0; i < n; i++) begin
         tick(1);
         chk("bp_stable", {evt_valid, evt_id, evt_long}, {1'b1, 3'd1, 1'b0});
      end
   endtask

   initial begin
      rst       = 1'b1;
      btn_in    = '0;
      evt_ready = 1'b1;
      ovf_clr   = 1'b0;
      tick(3);
      chk("rst_valid", evt_valid, 0);
      chk("rst_id",    evt_id,    0);
      chk("rst_long",  evt_long,  0);
      chk("rst_level", btn_level, 0);
      chk("rst_ovf",   ovf,       0);
      rst = 1'b0;
      tick(2);

      // 3-cycle glitch on ch0
      base = ev_n;
      btn_in[0] = 1'b1;
      tick(3);
      btn_in[0] = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick(1);
         chk("glitch_level", btn_level, 0);
      end
      chk("glitch_events", ev_n - base, 0);
      chk("glitch_ovf", ovf, 0);

      // short press ch1, level rises on the 6th edge
      base = ev_n;
      btn_in[1] = 1'b1;
      tick(5);
      chk("short_level_pre", btn_level[1], 0);
      tick(1);
      chk("short_level_rise", btn_level[1], 1);
      tick(6);
      btn_in[1] = 1'b0;
      tick(15);
      chk("short_events", ev_n - base, 1);
      chk("short_id",     ev_id_a[base], 1);
      chk("short_long",   ev_long_a[base], 0);
      chk("short_ovf",    ovf, 0);
      chk("short_level_fall", btn_level, 0);

      // long press ch2
      base = ev_n;
      btn_in[2] = 1'b1;
      tick(40);
      chk("long_hold_sat", dut.g_ch[2].u_ch.hold_cnt_q, LONG);
      btn_in[2] = 1'b0;
      tick(15);
      chk("long_events", ev_n - base, 1);
      chk("long_id",     ev_id_a[base], 2);
      chk("long_long",   ev_long_a[base], 1);

      // ch3 alone moves ptr back to 0
      base = ev_n;
      press(3, 10, 15);
      chk("ptr_setup_id", ev_id_a[base], 3);

      // simultaneous 0 and 3 with ptr=0
      base = ev_n;
      btn_in = 4'b1001;
      tick(10);
      btn_in = 4'b0000;
      tick(15);
      chk("fair0_events", ev_n - base, 2);
      chk("fair0_first",  ev_id_a[base], 0);
      chk("fair0_second", ev_id_a[base+1], 3);

      // ch0 alone -> ptr=1, then pair again
      base = ev_n;
      press(0, 10, 15);
      chk("ptr1_setup_id", ev_id_a[base], 0);
      base = ev_n;
      btn_in = 4'b1001;
      tick(10);
      btn_in = 4'b0000;
      tick(15);
      chk("fair1_events", ev_n - base, 2);
      chk("fair1_first",  ev_id_a[base], 3);
      chk("fair1_second", ev_id_a[base+1], 0);

      // backpressure: three presses on ch1 with evt_ready low
      evt_ready = 1'b0;
      base = ev_n;
      press(1, 10, 12);
      chk("bp_offer", {evt_valid, evt_id, evt_long}, {1'b1, 3'd1, 1'b0});
      for (int p = 0; p < 2; p++) begin
         btn_in[1] = 1'b1;
         hold_check(10);
         btn_in[1] = 1'b0;
         hold_check(12);
      end
      chk("bp_ovf", ovf, 4'b0010);
      chk("bp_none_delivered", ev_n - base, 0);
      evt_ready = 1'b1;
      tick(10);
      chk("bp_events", ev_n - base, 1);
      chk("bp_id",     ev_id_a[base], 1);
      chk("bp_long",   ev_long_a[base], 0);
      chk("bp_ovf_sticky", ovf, 4'b0010);
      ovf_clr = 1'b1;
      tick(1);
      ovf_clr = 1'b0;
      chk("ovf_cleared", ovf, 0);

      // new long release on ch1 lands exactly on its own handshake edge
      evt_ready = 1'b0;
      base = ev_n;
      press(1, 10, 12);
      chk("hs_offer", {evt_valid, evt_long}, 2'b10);
      btn_in[1] = 1'b1;
      tick(30);
      btn_in[1] = 1'b0;
      tick(5);
      evt_ready = 1'b1;
      tick(1);
      chk("hs_first_taken", ev_n - base, 1);
      chk("hs_ovf_edge", ovf, 0);
      tick(10);
      chk("hs_events", ev_n - base, 2);
      chk("hs_first_long",  ev_long_a[base], 0);
      chk("hs_second_id",   ev_id_a[base+1], 1);
      chk("hs_second_long", ev_long_a[base+1], 1);
      chk("hs_ovf", ovf, 0);

      // reset while offering
      evt_ready = 1'b0;
      press(2, 10, 12);
      chk("rst_mid_offer", evt_valid, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("rst_async_valid", evt_valid, 0);
      tick(2);
      rst = 1'b0;
      evt_ready = 1'b1;
      base = ev_n;
      tick(20);
      chk("rst_no_event", ev_n - base, 0);
      chk("rst_after_ovf", ovf, 0);
      chk("rst_after_level", btn_level, 0);
      base = ev_n;
      press(2, 10, 15);
      chk("rst_new_events", ev_n - base, 1);
      chk("rst_new_id", ev_id_a[base], 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
